multicycle_ctrl: RTL and testbench

Control sequencer for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. At each step it drives the datapath mux selects, including the 2-bit ALU operand-A select (`rs_sel`), the PC update select and the register/PC/IR write enables. It also handshakes with instruction and data memory, and enters a sticky fault state on illegal opcodes, SYSTEM instructions or memory timeout.

---
 rtl/rv_ctrl_pkg.sv | 80 ++++++++
 rtl/alu_decode.sv | 32 +++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states, ALU codes,
// opcodes, mux selects and fault causes, plus the opcode-to-class decoder.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR,
    CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
  } iclass_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RS_RS1    = 2'b00;
  localparam logic [1:0] RS_PC_BR  = 2'b01;
  localparam logic [1:0] RS_PC_J   = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_ALU    = 2'b01;
  localparam logic [1:0] PC_ALU_C0 = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

  function automatic iclass_t decode_class(input logic [6:0] op);
    iclass_t c;
    case (op)
      OP_R:      c = CLS_R;
      OP_IMM:    c = CLS_IMM;
      OP_LOAD:   c = CLS_LOAD;
      OP_STORE:  c = CLS_STORE;
      OP_BRANCH: c = CLS_BRANCH;
      OP_JAL:    c = CLS_JAL;
      OP_JALR:   c = CLS_JALR;
      OP_LUI:    c = CLS_LUI;
      OP_AUIPC:  c = CLS_AUIPC;
      OP_FENCE:  c = CLS_FENCE;
      OP_SYSTEM: c = CLS_SYSTEM;
      default:   c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Maps instruction class and funct fields onto the ALU operation code.
module alu_decode
  import rv_ctrl_pkg::*;
(
  input  iclass_t    cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  // Immediate ALU ops share the R-type table, but funct7_5 only selects SRA there
  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CLS_R, CLS_IMM: begin
        case (funct3)
          3'b000: alu_op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end
      CLS_LUI: alu_op = ALU_PASSB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// handshakes with memories and latches a sticky fault on illegal/system/timeout.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] rs_sel,
  output logic       b_sel,
  output logic [3:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     cur_state, nxt_state;
  iclass_t    cls;
  logic [7:0] wait_cnt;
  logic       timed_out;
  logic [1:0] cause_q, nxt_cause;
  logic [3:0] dec_alu_op;

  assign cls         = decode_class(opcode);
  assign timed_out   = (wait_cnt == TIMEOUT_CNT);
  assign state       = cur_state;
  assign fault_cause = cause_q;

  alu_decode u_alu_decode (
    .cls      (cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_RESET;
    else        cur_state <= nxt_state;
  end

  // Wait counter restarts on every transition; the cause is captured on fault entry only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (cur_state == ST_FETCH || cur_state == ST_MEM)
        wait_cnt <= wait_cnt + 8'd1;
      if (nxt_state == ST_FAULT && cur_state != ST_FAULT)
        cause_q <= nxt_cause;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_cause = CAUSE_NONE;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rs_sel    = RS_RS1;
    b_sel     = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    fault     = 1'b0;
    case (cur_state)
      ST_RESET: nxt_state = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          nxt_state = ST_DECODE;
        end else if (timed_out) begin
          nxt_state = ST_FAULT;
          nxt_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_SYSTEM: begin
            nxt_state = ST_FAULT;
            nxt_cause = CAUSE_SYSTEM;
          end
          CLS_ILLEGAL: begin
            nxt_state = ST_FAULT;
            nxt_cause = CAUSE_ILLEGAL;
          end
          default: nxt_state = ST_EXEC;
        endcase
      end
      // Branches resolve and retire here; everything else moves on to MEM or WB
      ST_EXEC: begin
        alu_op = dec_alu_op;
        b_sel  = (cls != CLS_R && cls != CLS_FENCE);
        if (cls == CLS_BRANCH)
          rs_sel = RS_PC_BR;
        else if (cls == CLS_JAL || cls == CLS_AUIPC)
          rs_sel = RS_PC_J;
        case (cls)
          CLS_LOAD, CLS_STORE: nxt_state = ST_MEM;
          CLS_BRANCH: begin
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_ALU : PC_PLUS4;
            nxt_state = ST_FETCH;
          end
          default: nxt_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we     = 1'b1;
            nxt_state = ST_FETCH;
          end else begin
            mdr_we    = 1'b1;
            nxt_state = ST_WB;
          end
        end else if (timed_out) begin
          nxt_state = ST_FAULT;
          nxt_cause = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_we    = (cls != CLS_FENCE);
        pc_we     = 1'b1;
        nxt_state = ST_FETCH;
        if (cls == CLS_LOAD)
          wb_sel = WB_MDR;
        else if (cls == CLS_JAL || cls == CLS_JALR)
          wb_sel = WB_PC4;
        if (cls == CLS_JAL)
          pc_sel = PC_ALU;
        else if (cls == CLS_JALR)
          pc_sel = PC_ALU_C0;
      end
      ST_FAULT: fault = 1'b1;
      default: nxt_state = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions run through a
// scoreboard, plus hand-written fault, timeout and reset sequences.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, br_taken, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, b_sel, reg_we, fault;
  logic [1:0] pc_sel, rs_sel, wb_sel, fault_cause;
  logic [3:0] alu_op;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       taken;
    int         iwait;
    int         dwait;
    logic [3:0] alu;
    logic [1:0] rs;
    logic       b;
    logic       rwe;
    logic [1:0] wb;
    logic [1:0] pcs;
    int         seq;
    int         dreq;
    int         dwe;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .rs_sel(rs_sel), .b_sel(b_sel),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .fault(fault),
    .fault_cause(fault_cause), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic tk, input int iw, input int dw,
                              input logic [3:0] a, input logic [1:0] rs, input logic b,
                              input logic rwe, input logic [1:0] wb, input logic [1:0] pcs,
                              input int sq, input int dq, input int dwe);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.taken = tk; v.iwait = iw; v.dwait = dw;
    v.alu = a; v.rs = rs; v.b = b; v.rwe = rwe; v.wb = wb; v.pcs = pcs;
    v.seq = sq; v.dreq = dq; v.dwe = dwe;
    return v;
  endfunction

  function automatic logic [23:0] allOut();
    return {imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, pc_sel, rs_sel, b_sel,
            alu_op, reg_we, wb_sel, fault, fault_cause, state};
  endfunction

  task automatic checkOutput(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Runs one instruction from FETCH until its pc_we, then scores it against the queue
  task automatic applyStimulus(input vec_t v);
    vec_t e;
    int wi = 0, wd = 0, cyc = 0, seq = 0, dreq = 0, dwe = 0, mdr = 0, mdrbad = 0, pcw = 0;
    logic rwe = 1'b0, done = 1'b0, b = 1'b0;
    logic [3:0] alu = '0;
    logic [1:0] rs = '0, wb = '0, pcs = '0;
    opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; br_taken = v.taken;
    sb.push_back(v);
    while (!done && cyc < 40 && state != ST_FAULT) begin
      imem_ready = (state == ST_FETCH) && (wi >= v.iwait);
      dmem_ready = (state == ST_MEM) && (wd >= v.dwait);
      #1;
      cyc++;
      seq = seq * 8 + int'(state);
      if (state == ST_EXEC) begin alu = alu_op; rs = rs_sel; b = b_sel; end
      if (reg_we) begin rwe = 1'b1; wb = wb_sel; end
      if (dmem_req) dreq++;
      if (dmem_we) dwe++;
      if (mdr_we) begin mdr++; if (!dmem_ready) mdrbad++; end
      if (pc_we) begin pcw++; pcs = pc_sel; done = 1'b1; end
      if (state == ST_FETCH && !imem_ready) wi++;
      if (state == ST_MEM && !dmem_ready) wd++;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    e = sb.pop_front();
    checkOutput({e.name, "_retired"}, int'(done), 1);
    checkOutput({e.name, "_seq"}, seq, e.seq);
    checkOutput({e.name, "_alu_op"}, int'(alu), int'(e.alu));
    checkOutput({e.name, "_rs_sel"}, int'(rs), int'(e.rs));
    checkOutput({e.name, "_b_sel"}, int'(b), int'(e.b));
    checkOutput({e.name, "_reg_we"}, int'(rwe), int'(e.rwe));
    checkOutput({e.name, "_wb_sel"}, int'(wb), int'(e.wb));
    checkOutput({e.name, "_pc_sel"}, int'(pcs), int'(e.pcs));
    checkOutput({e.name, "_pc_we_cnt"}, pcw, 1);
    checkOutput({e.name, "_dmem_req_cyc"}, dreq, e.dreq);
    checkOutput({e.name, "_dmem_we_cyc"}, dwe, e.dwe);
    checkOutput({e.name, "_mdr_we_cnt"}, mdr, (e.op == OP_LOAD) ? 1 : 0);
    checkOutput({e.name, "_mdr_we_early"}, mdrbad, 0);
    checkOutput({e.name, "_next_state"}, int'(state), int'(ST_FETCH));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives an instruction that must end in FAULT, then checks FAULT is absorbing
  task automatic runToFault(input string nm, input logic [6:0] op, input int iwait,
                            input logic [1:0] cause, input int exp_cyc);
    int cyc = 0, pcw = 0, left = 0, badcause = 0;
    opcode = op; funct3 = 3'b000; funct7_5 = 1'b0; br_taken = 1'b0;
    while (state != ST_FAULT && cyc < 40) begin
      imem_ready = (state == ST_FETCH) && (cyc >= iwait);
      #1;
      if (pc_we) pcw++;
      cyc++;
      @(negedge clk);
    end
    checkOutput({nm, "_state"}, int'(state), int'(ST_FAULT));
    checkOutput({nm, "_cycles"}, cyc, exp_cyc);
    checkOutput({nm, "_fault"}, int'(fault), 1);
    checkOutput({nm, "_cause"}, int'(fault_cause), int'(cause));
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      opcode = OP_R;
      #1;
      if (pc_we) pcw++;
      if (state != ST_FAULT || !fault) left++;
      if (fault_cause != cause) badcause++;
      @(negedge clk);
    end
    checkOutput({nm, "_sticky"}, left, 0);
    checkOutput({nm, "_cause_held"}, badcause, 0);
    checkOutput({nm, "_pc_we"}, pcw, 0);
  endtask

  initial begin
    vecs.push_back(mk("add",     OP_R,      3'b000, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("sub",     OP_R,      3'b000, 1'b1, 1'b0, 0, 0, ALU_SUB,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("sra",     OP_R,      3'b101, 1'b1, 1'b0, 0, 0, ALU_SRA,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("srl",     OP_R,      3'b101, 1'b0, 1'b0, 0, 0, ALU_SRL,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("sltu",    OP_R,      3'b011, 1'b0, 1'b0, 0, 0, ALU_SLTU,  RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("addi_f7", OP_IMM,    3'b000, 1'b1, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("srai",    OP_IMM,    3'b101, 1'b1, 1'b0, 0, 0, ALU_SRA,   RS_RS1,   1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("slli",    OP_IMM,    3'b001, 1'b0, 1'b0, 0, 0, ALU_SLL,   RS_RS1,   1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("ori",     OP_IMM,    3'b110, 1'b0, 1'b0, 0, 0, ALU_OR,    RS_RS1,   1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("beq_t",   OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, ALU_ADD,   RS_PC_BR, 1'b1, 1'b0, WB_ALU, PC_ALU,    'o123,       0, 0));
    vecs.push_back(mk("bne_nt",  OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_PC_BR, 1'b1, 1'b0, WB_ALU, PC_PLUS4,  'o123,       0, 0));
    vecs.push_back(mk("lw_w3",   OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 3, ALU_ADD,   RS_RS1,   1'b1, 1'b1, WB_MDR, PC_PLUS4,  'o12344445,  4, 0));
    vecs.push_back(mk("lw_w0",   OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b1, 1'b1, WB_MDR, PC_PLUS4,  'o12345,     1, 0));
    vecs.push_back(mk("lw_w4",   OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 4, ALU_ADD,   RS_RS1,   1'b1, 1'b1, WB_MDR, PC_PLUS4,  'o123444445, 5, 0));
    vecs.push_back(mk("sw",      OP_STORE,  3'b010, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b1, 1'b0, WB_ALU, PC_PLUS4,  'o1234,      1, 1));
    vecs.push_back(mk("sw_w2",   OP_STORE,  3'b010, 1'b0, 1'b0, 0, 2, ALU_ADD,   RS_RS1,   1'b1, 1'b0, WB_ALU, PC_PLUS4,  'o123444,    3, 3));
    vecs.push_back(mk("jal",     OP_JAL,    3'b000, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_PC_J,  1'b1, 1'b1, WB_PC4, PC_ALU,    'o1235,      0, 0));
    vecs.push_back(mk("jalr",    OP_JALR,   3'b000, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b1, 1'b1, WB_PC4, PC_ALU_C0, 'o1235,      0, 0));
    vecs.push_back(mk("lui",     OP_LUI,    3'b000, 1'b0, 1'b0, 0, 0, ALU_PASSB, RS_RS1,   1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("auipc",   OP_AUIPC,  3'b000, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_PC_J,  1'b1, 1'b1, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("fence",   OP_FENCE,  3'b000, 1'b0, 1'b0, 0, 0, ALU_ADD,   RS_RS1,   1'b0, 1'b0, WB_ALU, PC_PLUS4,  'o1235,      0, 0));
    vecs.push_back(mk("add_iw2", OP_R,      3'b000, 1'b0, 1'b0, 2, 0, ALU_ADD,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o111235,    0, 0));
    vecs.push_back(mk("add_iw4", OP_R,      3'b000, 1'b0, 1'b0, 4, 0, ALU_ADD,   RS_RS1,   1'b0, 1'b1, WB_ALU, PC_PLUS4,  'o11111235,  0, 0));

    rst_n = 1'b0;
    opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; br_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", int'(state), int'(ST_RESET));
    checkOutput("reset_outputs", int'(allOut()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_exit", int'(state), int'(ST_FETCH));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i]);

    // imem_ready stuck low with TIMEOUT = 4: five FETCH cycles, then FAULT
    runToFault("fetch_timeout", OP_R, 1000, CAUSE_TIMEOUT, 5);
    doReset();
    checkOutput("post_fault_reset", int'(state), int'(ST_FETCH));
    checkOutput("post_fault_cause", int'(fault_cause), int'(CAUSE_NONE));

    runToFault("illegal", 7'b0000000, 0, CAUSE_ILLEGAL, 2);
    doReset();
    runToFault("ecall", OP_SYSTEM, 0, CAUSE_SYSTEM, 2);
    doReset();

    // Reset pulled low while a load waits in MEM
    opcode = OP_LOAD; funct3 = 3'b010;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("mid_mem_state", int'(state), int'(ST_MEM));
    checkOutput("mid_mem_req", int'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_mem_reset_state", int'(state), int'(ST_RESET));
    checkOutput("mid_mem_reset_outputs", int'(allOut()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[vecs.size() - 1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
